// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_resolve_queue_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } brq_state_e;

  // Default entry layout; the queue packs {addr, pred} with pred in bit 0.
  localparam int unsigned BRQ_IDX_W = 3;

  typedef struct packed {
    logic [BRQ_IDX_W-1:0] addr;
    logic                 pred;
  } brq_entry_t;

  // Sticky error bit positions.
  localparam int unsigned ERR_PUSH  = 0;
  localparam int unsigned ERR_EMPTY = 1;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular buffer with push, pop and flush-to-head; flush empties the queue.
module brq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  // Next pointers, count and storage; flush discards everything behind the popped head.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = wdata;
      tail_d        = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    if (flush) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[head_q];
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; trains the predictor on
// retire and flushes wrong-path entries on a misprediction.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             PUSH,
  input  logic [IDX_W-1:0] PUSH_ADDR,
  input  logic             PUSH_PRED,
  input  logic             RESOLVE,
  input  logic             RESOLVE_TAKEN,
  output logic             FULL,
  output logic             EMPTY,
  output logic             BUSY,
  output logic             UPD_VALID,
  output logic [IDX_W-1:0] UPD_ADDR,
  output logic             UPD_OUTCOME,
  output logic             MISPREDICT,
  output logic [CNT_W-1:0] RESOLVED_CNT,
  output logic [CNT_W-1:0] MISS_CNT,
  output logic [1:0]       ERR
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  brq_state_e       state_q, state_d;
  logic             upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
  logic             upd_outcome_q, upd_outcome_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] resolved_q, resolved_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [1:0]       err_q, err_d;

  logic [IDX_W:0]   head_entry;
  logic             fifo_full, fifo_empty;
  logic             pop, mis_retire, push_ok;

  brq_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W + 1)
  ) u_fifo (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .push  (push_ok),
    .pop   (pop),
    .flush (mis_retire),
    .wdata ({PUSH_ADDR, PUSH_PRED}),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Retire/push qualification; a mispredict retire suppresses any same-cycle push silently.
  always_comb begin
    pop        = RESOLVE & ~fifo_empty;
    mis_retire = pop & (head_entry[0] != RESOLVE_TAKEN);
    push_ok    = PUSH & ~fifo_full & (state_q == ST_RUN) & ~mis_retire;
  end

  // Next state, registered update/flush outputs, statistics and sticky errors.
  always_comb begin
    state_d       = mis_retire ? ST_DRAIN : ST_RUN;
    upd_valid_d   = pop;
    upd_addr_d    = upd_addr_q;
    upd_outcome_d = upd_outcome_q;
    mispredict_d  = mis_retire;
    resolved_d    = resolved_q;
    miss_d        = miss_q;
    err_d         = err_q;
    if (pop) begin
      upd_addr_d    = head_entry[IDX_W:1];
      upd_outcome_d = RESOLVE_TAKEN;
      resolved_d    = resolved_q + CNT_ONE;
    end
    if (mis_retire) begin
      miss_d = miss_q + CNT_ONE;
    end
    if (PUSH & ~mis_retire & (fifo_full | (state_q == ST_DRAIN))) begin
      err_d[ERR_PUSH] = 1'b1;
    end
    if (RESOLVE & fifo_empty) begin
      err_d[ERR_EMPTY] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_RUN;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_outcome_q <= 1'b0;
      mispredict_q  <= 1'b0;
      resolved_q    <= '0;
      miss_q        <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_outcome_q <= upd_outcome_d;
      mispredict_q  <= mispredict_d;
      resolved_q    <= resolved_d;
      miss_q        <= miss_d;
      err_q         <= err_d;
    end
  end

  assign FULL         = fifo_full;
  assign EMPTY        = fifo_empty;
  assign BUSY         = (state_q == ST_DRAIN);
  assign UPD_VALID    = upd_valid_q;
  assign UPD_ADDR     = upd_addr_q;
  assign UPD_OUTCOME  = upd_outcome_q;
  assign MISPREDICT   = mispredict_q;
  assign RESOLVED_CNT = resolved_q;
  assign MISS_CNT     = miss_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, IDX_W=3, CNT_W=16).
module tb_branch_resolve_queue;

  logic        CLOCK;
  logic        RESET_N;
  logic        PUSH;
  logic [2:0]  PUSH_ADDR;
  logic        PUSH_PRED;
  logic        RESOLVE;
  logic        RESOLVE_TAKEN;
  logic        FULL;
  logic        EMPTY;
  logic        BUSY;
  logic        UPD_VALID;
  logic [2:0]  UPD_ADDR;
  logic        UPD_OUTCOME;
  logic        MISPREDICT;
  logic [15:0] RESOLVED_CNT;
  logic [15:0] MISS_CNT;
  logic [1:0]  ERR;

  int total;
  int fails;

  branch_resolve_queue #(
    .DEPTH (4),
    .IDX_W (3),
    .CNT_W (16)
  ) u_dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .PUSH          (PUSH),
    .PUSH_ADDR     (PUSH_ADDR),
    .PUSH_PRED     (PUSH_PRED),
    .RESOLVE       (RESOLVE),
    .RESOLVE_TAKEN (RESOLVE_TAKEN),
    .FULL          (FULL),
    .EMPTY         (EMPTY),
    .BUSY          (BUSY),
    .UPD_VALID     (UPD_VALID),
    .UPD_ADDR      (UPD_ADDR),
    .UPD_OUTCOME   (UPD_OUTCOME),
    .MISPREDICT    (MISPREDICT),
    .RESOLVED_CNT  (RESOLVED_CNT),
    .MISS_CNT      (MISS_CNT),
    .ERR           (ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic p, input logic [2:0] a, input logic pr,
                       input logic r, input logic t);
    PUSH          = p;
    PUSH_ADDR     = a;
    PUSH_PRED     = pr;
    RESOLVE       = r;
    RESOLVE_TAKEN = t;
  endtask

  initial begin
    total   = 0;
    fails   = 0;
    RESET_N = 1'b0;
    drive(0, 3'd0, 0, 0, 0);
    cyc();
    cyc();
    // Reset state
    chk("rst_empty",   32'(EMPTY), 1);
    chk("rst_full",    32'(FULL), 0);
    chk("rst_busy",    32'(BUSY), 0);
    chk("rst_updv",    32'(UPD_VALID), 0);
    chk("rst_miss",    32'(MISPREDICT), 0);
    chk("rst_rcnt",    32'(RESOLVED_CNT), 0);
    chk("rst_mcnt",    32'(MISS_CNT), 0);
    chk("rst_err",     32'(ERR), 0);
    RESET_N = 1'b1;
    cyc();
    cyc();
    chk("idle_updv",   32'(UPD_VALID), 0);
    chk("idle_empty",  32'(EMPTY), 1);

    // Two correctly predicted branches
    drive(1, 3'd1, 0, 0, 0);
    cyc();
    cyc();
    chk("p2_empty",    32'(EMPTY), 0);
    drive(0, 3'd0, 0, 1, 0);
    cyc();
    chk("r1_updv",     32'(UPD_VALID), 1);
    chk("r1_addr",     32'(UPD_ADDR), 1);
    chk("r1_out",      32'(UPD_OUTCOME), 0);
    chk("r1_mis",      32'(MISPREDICT), 0);
    cyc();
    chk("r2_updv",     32'(UPD_VALID), 1);
    chk("r2_addr",     32'(UPD_ADDR), 1);
    chk("r2_rcnt",     32'(RESOLVED_CNT), 2);
    chk("r2_mcnt",     32'(MISS_CNT), 0);
    chk("r2_empty",    32'(EMPTY), 1);
    drive(0, 3'd0, 0, 0, 0);
    cyc();
    chk("r2_idle_updv", 32'(UPD_VALID), 0);
    chk("r2_hold_addr", 32'(UPD_ADDR), 1);

    // Fill to DEPTH, overflow, push+resolve while full
    drive(1, 3'd3, 1, 0, 0); cyc();
    drive(1, 3'd4, 0, 0, 0); cyc();
    drive(1, 3'd5, 1, 0, 0); cyc();
    chk("f3_full",     32'(FULL), 0);
    drive(1, 3'd6, 0, 0, 0); cyc();
    chk("f4_full",     32'(FULL), 1);
    chk("f4_err",      32'(ERR), 0);
    drive(1, 3'd7, 1, 0, 0); cyc();
    chk("ovf_full",    32'(FULL), 1);
    chk("ovf_err",     32'(ERR), 1);
    drive(1, 3'd7, 1, 1, 1); cyc();
    chk("pr_updv",     32'(UPD_VALID), 1);
    chk("pr_addr",     32'(UPD_ADDR), 3);
    chk("pr_mis",      32'(MISPREDICT), 0);
    chk("pr_full",     32'(FULL), 0);
    drive(1, 3'd7, 1, 0, 0); cyc();
    chk("pa_full",     32'(FULL), 1);
    drive(0, 3'd0, 0, 1, 0); cyc();
    chk("d1_addr",     32'(UPD_ADDR), 4);
    drive(0, 3'd0, 0, 1, 1); cyc();
    chk("d2_addr",     32'(UPD_ADDR), 5);
    drive(0, 3'd0, 0, 1, 0); cyc();
    chk("d3_addr",     32'(UPD_ADDR), 6);
    drive(0, 3'd0, 0, 1, 1); cyc();
    chk("d4_addr",     32'(UPD_ADDR), 7);
    chk("d4_out",      32'(UPD_OUTCOME), 1);
    chk("d4_mis",      32'(MISPREDICT), 0);
    chk("d4_rcnt",     32'(RESOLVED_CNT), 7);
    chk("d4_mcnt",     32'(MISS_CNT), 0);
    chk("d4_empty",    32'(EMPTY), 1);

    // Resolve while empty
    drive(0, 3'd0, 0, 1, 0); cyc();
    chk("re_updv",     32'(UPD_VALID), 0);
    chk("re_err",      32'(ERR), 3);
    chk("re_rcnt",     32'(RESOLVED_CNT), 7);
    chk("re_addr",     32'(UPD_ADDR), 7);

    // Asynchronous reset mid-cycle with entries queued
    drive(1, 3'd1, 1, 0, 0); cyc();
    drive(1, 3'd2, 1, 0, 0); cyc();
    drive(1, 3'd3, 1, 0, 0); cyc();
    drive(0, 3'd0, 0, 0, 0);
    chk("pre_rst_empty", 32'(EMPTY), 0);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("ar_empty",    32'(EMPTY), 1);
    chk("ar_err",      32'(ERR), 0);
    chk("ar_rcnt",     32'(RESOLVED_CNT), 0);
    chk("ar_addr",     32'(UPD_ADDR), 0);
    cyc();
    RESET_N = 1'b1;
    cyc();
    chk("ar_rel_empty", 32'(EMPTY), 1);
    drive(1, 3'd2, 0, 0, 0); cyc();
    drive(0, 3'd0, 0, 1, 0); cyc();
    chk("ar_p_updv",   32'(UPD_VALID), 1);
    chk("ar_p_addr",   32'(UPD_ADDR), 2);
    chk("ar_p_rcnt",   32'(RESOLVED_CNT), 1);
    chk("ar_p_empty",  32'(EMPTY), 1);

    // Misprediction flush and DRAIN bubble
    drive(1, 3'd1, 0, 0, 0); cyc();
    drive(1, 3'd2, 1, 0, 0); cyc();
    drive(1, 3'd1, 0, 0, 0); cyc();
    drive(0, 3'd0, 0, 1, 1); cyc();
    chk("mp_mis",      32'(MISPREDICT), 1);
    chk("mp_updv",     32'(UPD_VALID), 1);
    chk("mp_addr",     32'(UPD_ADDR), 1);
    chk("mp_out",      32'(UPD_OUTCOME), 1);
    chk("mp_empty",    32'(EMPTY), 1);
    chk("mp_busy",     32'(BUSY), 1);
    chk("mp_mcnt",     32'(MISS_CNT), 1);
    chk("mp_rcnt",     32'(RESOLVED_CNT), 2);
    chk("mp_err",      32'(ERR), 0);
    drive(1, 3'd5, 1, 0, 0); cyc();
    chk("dr_mis",      32'(MISPREDICT), 0);
    chk("dr_busy",     32'(BUSY), 0);
    chk("dr_updv",     32'(UPD_VALID), 0);
    chk("dr_empty",    32'(EMPTY), 1);
    chk("dr_err",      32'(ERR), 1);
    drive(1, 3'd2, 1, 0, 0); cyc();
    chk("rn_empty",    32'(EMPTY), 0);
    drive(0, 3'd0, 0, 1, 1); cyc();
    chk("rn_addr",     32'(UPD_ADDR), 2);
    chk("rn_mis",      32'(MISPREDICT), 0);
    chk("rn_mcnt",     32'(MISS_CNT), 1);
    chk("rn_rcnt",     32'(RESOLVED_CNT), 3);
    chk("rn_empty2",   32'(EMPTY), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, sitting between the 2-bit counter predictor (fetch side) and the execute-stage branch unit.
- Captures each predicted branch's index and prediction at fetch. Retires entries in order as execute resolves them.
- On retire, drives the predictor's training update (index, actual outcome). On a misprediction, raises a one-cycle flush and discards all younger wrong-path entries.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
IDX_W, 3, predictor table index width
CNT_W, 16, statistics counter width

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
PUSH  in  1  fetch has a predicted branch this cycle
PUSH_ADDR  in  IDX_W  predictor index of that branch
PUSH_PRED  in  1  prediction given (1 = taken)
RESOLVE  in  1  execute resolves the oldest branch this cycle
RESOLVE_TAKEN  in  1  actual outcome of that branch
FULL  out  1  count == DEPTH
EMPTY  out  1  count == 0
BUSY  out  1  high while in DRAIN state
UPD_VALID  out  1  predictor update strobe (registered)
UPD_ADDR  out  IDX_W  index to train
UPD_OUTCOME  out  1  outcome to train with
MISPREDICT  out  1  one-cycle flush pulse (registered)
RESOLVED_CNT  out  CNT_W  total retired branches
MISS_CNT  out  CNT_W  total mispredictions
ERR  out  2  sticky: [0] push while full/drain, [1] resolve while empty

Behaviour:
- Reset (RESET_N low, asynchronous):
  - queue emptied; head = tail = count = 0; state = RUN
  - all outputs 0, except EMPTY = 1
  - counters and ERR cleared
  - takes effect mid-operation with no residue.
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- FULL/EMPTY: combinational from count.
- FSM, two states:
  - RUN: normal operation.
  - DRAIN: entered for exactly one cycle after a mispredict retire. In DRAIN, pushes are dropped (redirect bubble), BUSY = 1, and resolves are still honoured. Returns to RUN on the next cycle.
- Push:
  - accepted iff PUSH & !FULL & state == RUN & no mispredict retire in the same cycle.
  - stores {PUSH_ADDR, PUSH_PRED} at tail; tail++.
  - FULL is judged on the pre-edge count, so a push while full is rejected even if a resolve occurs in the same cycle.
  - a rejected push while full or in DRAIN sets ERR[0].
- Resolve:
  - accepted iff RESOLVE & !EMPTY; pops the head entry.
  - next cycle (1-cycle latency): UPD_VALID = 1, UPD_ADDR = entry index, UPD_OUTCOME = RESOLVE_TAKEN, MISPREDICT = (entry pred != RESOLVE_TAKEN).
  - RESOLVED_CNT increments; MISS_CNT increments on mismatch.
  - both counters wrap modulo 2^CNT_W.
  - RESOLVE while EMPTY: ignored, no update strobe, sets ERR[1].
- Mispredict retire:
  - same edge: head advances; all remaining entries are discarded (tail = head, count = 0); any simultaneous push is discarded without setting ERR; state goes to DRAIN.
  - MISPREDICT is high for exactly one cycle per mispredicted retire.
- Simultaneous push + correct resolve: both take effect; count unchanged; pointers each advance.
- Outputs not strobed: UPD_VALID and MISPREDICT are 0 in any cycle without a retire on the previous edge. UPD_ADDR and UPD_OUTCOME hold their last value.

Decomposition:
- Shared package: state encoding (ST_RUN, ST_DRAIN), entry struct {addr[IDX_W], pred}, ERR bit positions.
- Natural sub-module: `brq_fifo` (pointer/count circular buffer with push, pop and flush-to-head ports). The FSM, compare logic and counters stay in the top level.

Test Plan:
- Reset then idle → EMPTY = 1, FULL = 0, all counters 0, UPD_VALID never asserted.
- Push idx 1 pred 0 ×2, then resolve taken = 0 ×2 → two UPD_VALID pulses with UPD_ADDR = 1, UPD_OUTCOME = 0; MISPREDICT = 0; RESOLVED_CNT = 2, MISS_CNT = 0; EMPTY = 1.
- Push idx 1 pred 0, idx 2 pred 1, idx 1 pred 0; resolve taken = 1 → MISPREDICT pulse 1 cycle later; count = 0; BUSY = 1 for one cycle; push during that cycle dropped; MISS_CNT = 1.
- Push 4 entries (DEPTH = 4), push a 5th → FULL = 1, 5th rejected, ERR[0] = 1. Then simultaneous push + correct resolve → rejected again (pre-edge FULL). Next cycle, push accepted.
- Resolve with empty queue → no UPD_VALID, ERR[1] = 1, counters unchanged.
- Fill 3 entries, assert RESET_N low mid-cycle → outputs clear immediately (asynchronous); after release, EMPTY = 1 and the first push lands at slot 0.
